head_table_resp: RTL and testbench
==================================

Name: head_table_resp

Overview:
- Responder end of the head-table interface: owns the bucket→head-pointer RAM.
- Engines in the data table write to this RAM.
- On the lookup side, it receives hashed tasks, reads each bucket's head pointer, and forwards the task plus head pointer downstream to the data table task input.
- It also performs the table-wide clear used by the INIT opcode and after reset.

Parameters:
BUCKET_WIDTH, 8, bucket address width; table has 2**BUCKET_WIDTH entries
PTR_WIDTH, 10, head pointer width (data-table address)
PAYLOAD_WIDTH, 64, opaque task payload carried alongside the bucket
FIFO_DEPTH, 4, output buffer depth; must be ≥ 3 and a power of two

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
lkp_bucket_i  in  BUCKET_WIDTH  bucket to look up
lkp_payload_i  in  PAYLOAD_WIDTH  task carried through
lkp_valid_i  in  1  lookup request valid
lkp_ready_o  out  1  lookup accepted when valid&&ready
out_bucket_o  out  BUCKET_WIDTH  bucket of result
out_payload_o  out  PAYLOAD_WIDTH  payload of result
out_head_ptr_o  out  PTR_WIDTH  head pointer stored for bucket
out_head_ptr_val_o  out  1  bucket non-empty
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts result
wr_en_i  in  1  head-table write strobe from engines
wr_bucket_i  in  BUCKET_WIDTH  write address
wr_head_ptr_i  in  PTR_WIDTH  new head pointer
wr_head_ptr_val_i  in  1  new valid flag (0 = bucket empty)
clear_run_i  in  1  pulse: clear entire table
clear_done_o  out  1  one-cycle pulse when clear completes
busy_o  out  1  clear in progress

Behaviour:
- Reset values (rst_i low, async):
  - out_valid_o=0, clear_done_o=0, busy_o=1, lkp_ready_o=0.
  - FIFO empty, in-flight count 0.
  - FSM = CLEAR, clear address = 0.
  - RAM contents are not reset; the automatic clear after reset defines them.
- RAM: one {val, ptr} word per bucket; read port dedicated to lookups, write port shared by clear and wr_en_i. Read latency 2 cycles (registered output).
- FSM IDLE:
  - lkp_ready_o = (fifo_count + inflight) < FIFO_DEPTH.
  - clear_run_i → CLEAR with address 0; lookups already in flight complete normally.
- FSM CLEAR:
  - Writes {val=0, ptr=0} to address N in cycle N: 2**BUCKET_WIDTH cycles total.
  - lkp_ready_o=0, busy_o=1. wr_en_i and clear_run_i are ignored.
  - After the last address is written: clear_done_o=1 for exactly one cycle, busy_o=0, FSM → IDLE.
- Lookup pipeline:
  - Accepted request → RAM read → result enters the FIFO exactly 2 cycles after acceptance.
  - out_* presents the FIFO head; it is popped on out_valid_o && out_ready_i.
  - Minimum latency from acceptance to out_valid_o = 3 cycles: 2 RAM + 1 FIFO register.
  - Order is preserved. Throughput is 1 lookup/cycle while out_ready_i=1.
- Hazard forwarding (no stale reads):
  - If wr_en_i writes bucket B in the acceptance cycle of a lookup of B, or while that lookup is in either read stage, the result carries the written {val, ptr}.
  - When multiple writes hit B during the window, the youngest write wins.
- Width rules: bucket indexes the table directly; no wrap. The clear counter is BUCKET_WIDTH+1 bits so the terminal count is detectable.
- Boundaries:
  - FIFO full plus in-flight → lkp_ready_o=0; no result is ever dropped.
  - Simultaneous pop and push keeps the count unchanged.
  - out_valid_o is held stable with stable data until popped.
  - clear_run_i in the same cycle as a lookup handshake: the lookup is accepted and reads pre-clear data.
  - Reset mid-clear restarts the clear from address 0.

Test Plan:
- Release reset → busy_o=1 for 256 cycles; clear_done_o pulses once; then lkp_ready_o=1. Lookup buckets 0,128,255 → each out_head_ptr_val_o=0.
- Write bucket 5 ptr=0x3A val=1, wait 1 cycle, lookup 5 with payload 0xDEAD → 3 cycles later out_head_ptr_o=0x3A, val=1, payload=0xDEAD.
- Lookup bucket 7 and write bucket 7 ptr=0x11 val=1 in the same cycle → result ptr=0x11, val=1. Repeat with the write 1 cycle after acceptance → same result.
- Hold out_ready_i=0 and stream lookups → exactly 4 accepted, then lkp_ready_o=0 and out_* stable. Release → 4 results in issue order, then streaming resumes at 1/cycle.
- Populate buckets 1..3, pulse clear_run_i, drive wr_en_i during the clear → writes ignored; clear_done_o after 256 cycles; lookups of 1..3 return val=0.
- Assert rst_i low at clear address 100, release → clear restarts at 0 and takes the full 256 cycles before clear_done_o.

Source files
------------

// File: rtl/head_table_resp.sv
// head_table_resp: responder side of the head-table interface.
// Owns the bucket -> {val, ptr} RAM, serves pipelined lookups with write
// forwarding into a small result FIFO, and runs the table-wide clear.
module head_table_resp #(
  parameter int unsigned BUCKET_WIDTH  = 8,
  parameter int unsigned PTR_WIDTH     = 10,
  parameter int unsigned PAYLOAD_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [BUCKET_WIDTH-1:0]  lkp_bucket_i,
  input  logic [PAYLOAD_WIDTH-1:0] lkp_payload_i,
  input  logic                     lkp_valid_i,
  output logic                     lkp_ready_o,
  output logic [BUCKET_WIDTH-1:0]  out_bucket_o,
  output logic [PAYLOAD_WIDTH-1:0] out_payload_o,
  output logic [PTR_WIDTH-1:0]     out_head_ptr_o,
  output logic                     out_head_ptr_val_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  input  logic                     wr_en_i,
  input  logic [BUCKET_WIDTH-1:0]  wr_bucket_i,
  input  logic [PTR_WIDTH-1:0]     wr_head_ptr_i,
  input  logic                     wr_head_ptr_val_i,
  input  logic                     clear_run_i,
  output logic                     clear_done_o,
  output logic                     busy_o
);

  localparam int unsigned ENTRIES = 1 << BUCKET_WIDTH;
  localparam int unsigned WORD_W  = PTR_WIDTH + 1;
  localparam int unsigned CLR_W   = BUCKET_WIDTH + 1;
  localparam int unsigned FA_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W   = CNT_W + 1;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  typedef struct packed {
    logic [BUCKET_WIDTH-1:0]  bucket;
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic                     val;
    logic [PTR_WIDTH-1:0]     ptr;
  } result_t;

  logic [WORD_W-1:0] mem [ENTRIES];

  state_t                   state_q, state_d;
  logic [CLR_W-1:0]         clr_addr_q, clr_addr_d;
  logic                     busy_d, done_d, ready_d;
  logic                     ram_we;
  logic [BUCKET_WIDTH-1:0]  ram_waddr;
  logic [WORD_W-1:0]        ram_wdata;

  logic                     user_we, accept, push, pop;
  logic [WORD_W-1:0]        user_wdata, push_word;

  logic                     s1_valid_q, s2_valid_q;
  logic [BUCKET_WIDTH-1:0]  s1_bucket_q, s2_bucket_q;
  logic [PAYLOAD_WIDTH-1:0] s1_payload_q, s2_payload_q;
  logic [WORD_W-1:0]        s1_word_q, s2_word_q;

  result_t                  fifo_mem [FIFO_DEPTH];
  result_t                  head;
  logic [FA_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [SUM_W-1:0]         credit_d;

  // Engine writes only land while idle; a running clear owns the write port.
  assign user_we    = wr_en_i && (state_q == ST_IDLE);
  assign user_wdata = {wr_head_ptr_val_i, wr_head_ptr_i};
  assign accept     = lkp_valid_i && lkp_ready_o;
  assign push       = s2_valid_q;
  assign pop        = out_valid_o && out_ready_i;
  assign push_word  = (user_we && (wr_bucket_i == s2_bucket_q)) ? user_wdata : s2_word_q;
  assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
  assign credit_d   = SUM_W'(count_d) + SUM_W'(accept) + SUM_W'(s1_valid_q);

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next state, RAM write-port arbitration and next values of control outputs.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_bucket_i;
    ram_wdata  = user_wdata;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ram_we = wr_en_i;
        if (clear_run_i) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        ram_we     = 1'b1;
        ram_waddr  = clr_addr_q[BUCKET_WIDTH-1:0];
        ram_wdata  = '0;
        clr_addr_d = clr_addr_q + CLR_W'(1);
        if (clr_addr_d[BUCKET_WIDTH]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    busy_d  = (state_d == ST_CLEAR);
    ready_d = (state_d == ST_IDLE) && (credit_d < SUM_W'(FIFO_DEPTH));
  end

  // Registered control outputs, pipeline valids and FIFO bookkeeping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_o       <= 1'b1;
      clear_done_o <= 1'b0;
      lkp_ready_o  <= 1'b0;
      out_valid_o  <= 1'b0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      busy_o       <= busy_d;
      clear_done_o <= done_d;
      lkp_ready_o  <= ready_d;
      out_valid_o  <= (count_d != '0);
      s1_valid_q   <= accept;
      s2_valid_q   <= s1_valid_q;
      count_q      <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + FA_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FA_W'(1);
    end
  end

  // Head-table RAM write port (contents defined by the clear, not by reset).
  always_ff @(posedge clk_i) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  // Two-stage read with forwarding of engine writes that hit the bucket in flight.
  always_ff @(posedge clk_i) begin
    s1_bucket_q  <= lkp_bucket_i;
    s1_payload_q <= lkp_payload_i;
    s1_word_q    <= (user_we && (wr_bucket_i == lkp_bucket_i)) ? user_wdata : mem[lkp_bucket_i];
    s2_bucket_q  <= s1_bucket_q;
    s2_payload_q <= s1_payload_q;
    s2_word_q    <= (user_we && (wr_bucket_i == s1_bucket_q)) ? user_wdata : s1_word_q;
    if (push) fifo_mem[wr_ptr_q] <= {s2_bucket_q, s2_payload_q, push_word};
  end

  // Result outputs present the FIFO head.
  assign head               = fifo_mem[rd_ptr_q];
  assign out_bucket_o       = head.bucket;
  assign out_payload_o      = head.payload;
  assign out_head_ptr_o     = head.ptr;
  assign out_head_ptr_val_o = head.val;

endmodule

// File: tb/tb_head_table_resp.sv
// Bench for head_table_resp: directed stimulus, a transaction-level model of
// the table/lookup/clear behaviour, and a per-cycle compare against it.
module tb_head_table_resp;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  lkp_bucket_i;
  logic [63:0] lkp_payload_i;
  logic        lkp_valid_i;
  logic        lkp_ready_o;
  logic [7:0]  out_bucket_o;
  logic [63:0] out_payload_o;
  logic [9:0]  out_head_ptr_o;
  logic        out_head_ptr_val_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        wr_en_i;
  logic [7:0]  wr_bucket_i;
  logic [9:0]  wr_head_ptr_i;
  logic        wr_head_ptr_val_i;
  logic        clear_run_i;
  logic        clear_done_o;
  logic        busy_o;

  head_table_resp dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lkp_bucket_i(lkp_bucket_i), .lkp_payload_i(lkp_payload_i),
    .lkp_valid_i(lkp_valid_i), .lkp_ready_o(lkp_ready_o),
    .out_bucket_o(out_bucket_o), .out_payload_o(out_payload_o),
    .out_head_ptr_o(out_head_ptr_o), .out_head_ptr_val_o(out_head_ptr_val_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .wr_en_i(wr_en_i), .wr_bucket_i(wr_bucket_i),
    .wr_head_ptr_i(wr_head_ptr_i), .wr_head_ptr_val_i(wr_head_ptr_val_i),
    .clear_run_i(clear_run_i), .clear_done_o(clear_done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]  bucket;
    logic [63:0] payload;
    logic        val;
    logic [9:0]  ptr;
    int          age;
  } ent_t;

  ent_t        pend[$];
  ent_t        nxt[$];
  ent_t        mfifo[$];
  ent_t        e;
  logic [10:0] mtable [256];
  bit          m_clearing = 1'b1;
  int          m_left = 256;
  bit          m_done = 1'b0;
  bit          m_ready = 1'b0;
  bit          m_acc, m_pop, m_uw;

  // Model: table of words, lookups snapshot at acceptance and absorb engine
  // writes for three cycles, then appear at the result queue tail.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      m_clearing = 1'b1;
      m_left     = 256;
      m_done     = 1'b0;
      m_ready    = 1'b0;
      pend.delete();
      mfifo.delete();
      for (int i = 0; i < 256; i++) mtable[i] = '0;
    end else begin
      m_acc = lkp_valid_i && m_ready;
      m_pop = out_ready_i && (mfifo.size() > 0);
      m_uw  = wr_en_i && !m_clearing;
      if (m_pop) void'(mfifo.pop_front());
      nxt.delete();
      foreach (pend[i]) begin
        e = pend[i];
        if (m_uw && e.bucket == wr_bucket_i) begin
          e.val = wr_head_ptr_val_i;
          e.ptr = wr_head_ptr_i;
        end
        if (e.age == 1) mfifo.push_back(e);
        else begin
          e.age = e.age + 1;
          nxt.push_back(e);
        end
      end
      if (m_acc) begin
        e.bucket  = lkp_bucket_i;
        e.payload = lkp_payload_i;
        {e.val, e.ptr} = mtable[lkp_bucket_i];
        if (m_uw && wr_bucket_i == lkp_bucket_i) begin
          e.val = wr_head_ptr_val_i;
          e.ptr = wr_head_ptr_i;
        end
        e.age = 0;
        nxt.push_back(e);
      end
      pend = nxt;
      if (m_uw) mtable[wr_bucket_i] = {wr_head_ptr_val_i, wr_head_ptr_i};
      m_done = 1'b0;
      if (m_clearing) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_clearing = 1'b0;
          m_done     = 1'b1;
        end
      end else if (clear_run_i) begin
        m_clearing = 1'b1;
        m_left     = 256;
        for (int i = 0; i < 256; i++) mtable[i] = '0;
      end
      m_ready = !m_clearing && ((mfifo.size() + pend.size()) < 4);
    end
  end

  // Per-cycle compare on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      chk("busy", busy_o, m_clearing);
      chk("clear_done", clear_done_o, m_done);
      chk("lkp_ready", lkp_ready_o, m_ready);
      chk("out_valid", out_valid_o, mfifo.size() > 0);
      if (mfifo.size() > 0) begin
        chk("out_bucket", out_bucket_o, mfifo[0].bucket);
        chk("out_payload", out_payload_o, mfifo[0].payload);
        chk("out_ptr", out_head_ptr_o, mfifo[0].ptr);
        chk("out_ptr_val", out_head_ptr_val_o, mfifo[0].val);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input int b, input int p, input bit v);
    wr_en_i = 1'b1; wr_bucket_i = 8'(b); wr_head_ptr_i = 10'(p); wr_head_ptr_val_i = v;
    tick();
    wr_en_i = 1'b0;
  endtask

  // Returns one cycle after the acceptance edge.
  task automatic do_lookup(input int b, input logic [63:0] pl);
    int n = 0;
    lkp_valid_i = 1'b1; lkp_bucket_i = 8'(b); lkp_payload_i = pl;
    while (!lkp_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (lkp_ready_o) tick();
    else chk("lookup_timeout", 0, 1);
    lkp_valid_i = 1'b0;
  endtask

  task automatic count_clear(output int nb, output int nd);
    nb = 0; nd = 0;
    for (int k = 0; k < 300; k++) begin
      if (busy_o) nb++;
      if (clear_done_o) nd++;
      tick();
    end
  endtask

  int nb, nd, acc, b;
  bit go;

  initial begin
    lkp_bucket_i = '0; lkp_payload_i = '0; lkp_valid_i = 1'b0; out_ready_i = 1'b1;
    wr_en_i = 1'b0; wr_bucket_i = '0; wr_head_ptr_i = '0; wr_head_ptr_val_i = 1'b0;
    clear_run_i = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy_o, 1);
    chk("rst_ready", lkp_ready_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_clear_done", clear_done_o, 0);

    // Boot clear
    rst_i = 1'b1;
    count_clear(nb, nd);
    chk("boot_busy_cycles", nb, 256);
    chk("boot_done_pulses", nd, 1);
    chk("ready_after_boot", lkp_ready_o, 1);

    do_lookup(0, 64'h1);
    do_lookup(128, 64'h2);
    do_lookup(255, 64'h3);
    repeat (5) tick();

    // Plain write then lookup: result 3 cycles after acceptance
    do_write(5, 'h3A, 1'b1);
    tick();
    do_lookup(5, 64'hDEAD);
    tick(); tick();
    chk("b5_valid", out_valid_o, 1);
    chk("b5_ptr", out_head_ptr_o, 10'h3A);
    chk("b5_val", out_head_ptr_val_o, 1);
    chk("b5_payload", out_payload_o, 64'hDEAD);
    repeat (3) tick();

    // Write in the acceptance cycle
    chk("ready_before_hazard", lkp_ready_o, 1);
    lkp_valid_i = 1'b1; lkp_bucket_i = 8'd7; lkp_payload_i = 64'h77;
    wr_en_i = 1'b1; wr_bucket_i = 8'd7; wr_head_ptr_i = 10'h11; wr_head_ptr_val_i = 1'b1;
    tick();
    lkp_valid_i = 1'b0; wr_en_i = 1'b0;
    tick(); tick();
    chk("b7_same_ptr", out_head_ptr_o, 10'h11);
    chk("b7_same_val", out_head_ptr_val_o, 1);
    chk("b7_same_payload", out_payload_o, 64'h77);
    repeat (3) tick();

    // Write one cycle after acceptance
    do_write(7, 'h05, 1'b0);
    tick();
    do_lookup(7, 64'h78);
    wr_en_i = 1'b1; wr_bucket_i = 8'd7; wr_head_ptr_i = 10'h11; wr_head_ptr_val_i = 1'b1;
    tick();
    wr_en_i = 1'b0;
    tick();
    chk("b7_late_ptr", out_head_ptr_o, 10'h11);
    chk("b7_late_val", out_head_ptr_val_o, 1);
    repeat (3) tick();

    // Several writes across the read window: youngest wins
    lkp_valid_i = 1'b1; lkp_bucket_i = 8'd9; lkp_payload_i = 64'h99;
    wr_en_i = 1'b1; wr_bucket_i = 8'd9; wr_head_ptr_i = 10'h21; wr_head_ptr_val_i = 1'b1;
    tick();
    lkp_valid_i = 1'b0; wr_head_ptr_i = 10'h22;
    tick();
    wr_head_ptr_i = 10'h23; wr_head_ptr_val_i = 1'b0;
    tick();
    wr_en_i = 1'b0;
    chk("b9_young_ptr", out_head_ptr_o, 10'h23);
    chk("b9_young_val", out_head_ptr_val_o, 0);
    repeat (3) tick();
    do_lookup(9, 64'h9A);
    repeat (4) tick();

    // Backpressure: exactly FIFO_DEPTH accepted, then drain and resume
    out_ready_i = 1'b0;
    b = 10; acc = 0;
    lkp_valid_i = 1'b1; lkp_bucket_i = 8'(b); lkp_payload_i = 64'h1000 + 64'(b);
    for (int k = 0; k < 12; k++) begin
      go = lkp_ready_o;
      if (go) acc++;
      tick();
      if (go) begin
        b++;
        lkp_bucket_i = 8'(b); lkp_payload_i = 64'h1000 + 64'(b);
      end
    end
    chk("stall_accepted", acc, 4);
    chk("stall_ready", lkp_ready_o, 0);
    chk("stall_head_bucket", out_bucket_o, 8'd10);
    chk("stall_head_payload", out_payload_o, 64'h100A);
    out_ready_i = 1'b1;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      go = lkp_ready_o;
      if (go) acc++;
      tick();
      if (go) begin
        b++;
        lkp_bucket_i = 8'(b); lkp_payload_i = 64'h1000 + 64'(b);
      end
    end
    chk("resume_accepted", acc, 19);
    lkp_valid_i = 1'b0;
    repeat (8) tick();

    // Clear with a simultaneous lookup and engine writes during the clear
    do_write(1, 'h101, 1'b1);
    do_write(2, 'h102, 1'b1);
    do_write(3, 'h103, 1'b1);
    tick();
    lkp_valid_i = 1'b1; lkp_bucket_i = 8'd1; lkp_payload_i = 64'hC1; clear_run_i = 1'b1;
    tick();
    lkp_valid_i = 1'b0; clear_run_i = 1'b0;
    nb = 0; nd = 0;
    for (int k = 0; k < 300; k++) begin
      if (busy_o) nb++;
      if (clear_done_o) nd++;
      if (k == 2) begin
        chk("preclear_valid", out_valid_o, 1);
        chk("preclear_ptr", out_head_ptr_o, 10'h101);
        chk("preclear_val", out_head_ptr_val_o, 1);
      end
      wr_en_i = (k < 255); wr_bucket_i = 8'd2; wr_head_ptr_i = 10'h3FF; wr_head_ptr_val_i = 1'b1;
      clear_run_i = (k == 50);
      tick();
    end
    wr_en_i = 1'b0; clear_run_i = 1'b0;
    chk("clear_busy_cycles", nb, 256);
    chk("clear_done_pulses", nd, 1);
    do_lookup(1, 64'hA1);
    do_lookup(2, 64'hA2);
    tick();
    chk("cleared_b2_val", out_head_ptr_val_o, 0);
    chk("cleared_b2_ptr", out_head_ptr_o, 10'h0);
    do_lookup(3, 64'hA3);
    repeat (4) tick();

    // Reset in the middle of a clear restarts it from address 0
    do_write(200, 'h0C8, 1'b1);
    tick();
    clear_run_i = 1'b1;
    tick();
    clear_run_i = 1'b0;
    repeat (100) tick();
    rst_i = 1'b0;
    repeat (2) tick();
    chk("midreset_busy", busy_o, 1);
    chk("midreset_ready", lkp_ready_o, 0);
    rst_i = 1'b1;
    count_clear(nb, nd);
    chk("restart_busy_cycles", nb, 256);
    chk("restart_done_pulses", nd, 1);
    do_lookup(200, 64'hC8);
    tick();
    chk("b200_val", out_head_ptr_val_o, 0);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
